// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the two-master data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_arb_pkg;

    // Width of the consecutive master-0 grant counter.
    localparam int BURST_W = 4;

    // The last grant recorded by the arbiter FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    // Owner tag for one in-flight read.
    typedef struct packed {
        logic       valid;
        master_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the arbiter: two master request/response ports and the memory port.
// Latency: n/a (wires only).
// Backpressure: mN_stall tells a master to hold its request; the memory port never stalls.
// Ports: m0_*/m1_* master ports, data_* memory port, busy (a read is in flight).
// slave  = arbiter view (takes master requests, drives memory)
// master = environment view (issues requests, returns memory data)
interface data_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] m0_address;
    logic          m0_read;
    logic          m0_write;
    logic [DW-1:0] m0_writedata;
    logic          m0_stall;
    logic [DW-1:0] m0_readdata;
    logic          m0_rvalid;

    logic [AW-1:0] m1_address;
    logic          m1_read;
    logic          m1_write;
    logic [DW-1:0] m1_writedata;
    logic          m1_stall;
    logic [DW-1:0] m1_readdata;
    logic          m1_rvalid;

    logic [AW-1:0] data_address;
    logic          data_read;
    logic          data_write;
    logic [DW-1:0] data_writedata;
    logic [DW-1:0] data_readdata;

    logic          busy;

    modport slave (
        input  m0_address, m0_read, m0_write, m0_writedata,
        output m0_stall, m0_readdata, m0_rvalid,
        input  m1_address, m1_read, m1_write, m1_writedata,
        output m1_stall, m1_readdata, m1_rvalid,
        output data_address, data_read, data_write, data_writedata,
        input  data_readdata,
        output busy
    );

    modport master (
        output m0_address, m0_read, m0_write, m0_writedata,
        input  m0_stall, m0_readdata, m0_rvalid,
        output m1_address, m1_read, m1_write, m1_writedata,
        input  m1_stall, m1_readdata, m1_rvalid,
        input  data_address, data_read, data_write, data_writedata,
        output data_readdata,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter_rd_tag_pipe.sv
// Shift pipe of read owner tags, one stage per cycle of memory read latency.
// Latency: DEPTH cycles from tag_i to tag_o.
// Backpressure: none; en_i low freezes every stage.
// Ports: clk, rst_n (async active-low), en_i, tag_i (push), tag_o (oldest), busy_o (any valid).
module rd_tag_pipe
    import data_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o,
    output logic    busy_o
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en_i) begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_o = busy_o | pipe_q[i].valid;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for a single-ported data memory; master 0 has priority, master 1 starves at most MAX_BURST cycles.
// Latency: grant/memory strobes combinational with the request; read response RD_LATENCY cycles after grant.
// Backpressure: losing master sees mN_stall and holds its request; clk_enable low stalls every requester.
// Ports: clk, reset_n (async active-low), clk_enable, bus (slave modport: m0/m1 ports, memory port, busy).
module data_mem_arbiter
    import data_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_enable,
    data_mem_arbiter_if.slave bus
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    arb_state_t         state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [BURST_W-1:0] cnt_base;
    logic               req0, req1;
    logic               gnt0, gnt1;
    logic [AW-1:0]      addr_mux;
    logic [DW-1:0]      wdata_mux;
    logic               rd_mux, wr_mux;
    rd_tag_t            tag_in, tag_out;
    logic               rvalid0, rvalid1;
    logic [DW-1:0]      rdata0_q, rdata1_q;
    logic               pipe_busy;

    assign req0 = bus.m0_read | bus.m0_write;
    assign req1 = bus.m1_read | bus.m1_write;

    // The count only carries over while the previous grant was also to master 0.
    assign cnt_base = (state_q == GNT0) ? burst_cnt_q : '0;

    // Grant decision and next state. Nothing is granted while held in reset or frozen.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (reset_n && clk_enable) begin
            if (req0 && (!req1 || burst_cnt_q < MAX_B)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end

            if (gnt0) begin
                state_d = GNT0;
            end else if (gnt1) begin
                state_d = GNT1;
            end else begin
                state_d = IDLE;
            end

            // Only count master-0 wins that master 1 actually had to wait through.
            if (gnt0 && req1) begin
                burst_cnt_d = (cnt_base >= MAX_B) ? MAX_B : cnt_base + 1'b1;
            end else begin
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else if (clk_enable) begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Memory port mux; a simultaneous read+write is issued as a write only.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        rd_mux    = 1'b0;
        wr_mux    = 1'b0;
        if (gnt0) begin
            addr_mux  = bus.m0_address;
            wdata_mux = bus.m0_writedata;
            rd_mux    = bus.m0_read & ~bus.m0_write;
            wr_mux    = bus.m0_write;
        end else if (gnt1) begin
            addr_mux  = bus.m1_address;
            wdata_mux = bus.m1_writedata;
            rd_mux    = bus.m1_read & ~bus.m1_write;
            wr_mux    = bus.m1_write;
        end
    end

    assign bus.data_address   = addr_mux;
    assign bus.data_writedata = wdata_mux;
    assign bus.data_read      = rd_mux;
    assign bus.data_write     = wr_mux;

    // Stalls are forced low during reset so a requester never sees a stale stall.
    assign bus.m0_stall = reset_n & req0 & ~gnt0;
    assign bus.m1_stall = reset_n & req1 & ~gnt1;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = rd_mux;
        tag_in.id    = gnt1 ? master_id_t'(1'b1) : master_id_t'(1'b0);
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk    (clk),
        .rst_n  (reset_n),
        .en_i   (clk_enable),
        .tag_i  (tag_in),
        .tag_o  (tag_out),
        .busy_o (pipe_busy)
    );

    assign bus.busy = pipe_busy;

    // The tag pipe holds while frozen, so the strobe is masked to keep it one-shot.
    assign rvalid0 = clk_enable & tag_out.valid & (tag_out.id == 1'b0);
    assign rvalid1 = clk_enable & tag_out.valid & (tag_out.id == 1'b1);

    // Each master's readdata shows live memory data on its strobe and holds it afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) begin
                rdata0_q <= bus.data_readdata;
            end
            if (rvalid1) begin
                rdata1_q <= bus.data_readdata;
            end
        end
    end

    assign bus.m0_rvalid   = rvalid0;
    assign bus.m1_rvalid   = rvalid1;
    assign bus.m0_readdata = rvalid0 ? bus.data_readdata : rdata0_q;
    assign bus.m1_readdata = rvalid1 ? bus.data_readdata : rdata1_q;

endmodule
